imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Synthesizable loader upstream of mips_pipeline: receives a byte stream (header, program words, checksum),
//  writes assembled 32-bit instructions into instruction memory via its write port, and holds the pipeline
//  in reset (cpu_rst, same polarity as pc_rst) until a complete, checksum-valid image is loaded.
//  Replaces $readmemh of the IM image for hardware bring-up; BHT/DM/RF preload are out of scope.
// PARAMETERS
//  IMEM_DEPTH  256  instruction memory depth in words; max accepted word count
//  ADDR_W      8    im_addr width, must satisfy 2**ADDR_W >= IMEM_DEPTH
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  rst_n     in   1       asynchronous active-low reset
//  s_valid   in   1       input byte valid
//  s_data    in   8       input byte
//  s_ready   out  1       loader accepts byte this cycle (transfer = s_valid & s_ready)
//  reload    in   1       1-cycle request to restart loading (honoured only in DONE/ERR)
//  im_we     out  1       instruction memory write strobe, one cycle per word
//  im_addr   out  ADDR_W  word index being written
//  im_wdata  out  32      assembled instruction word
//  cpu_rst   out  1       active-high hold to pipeline pc_rst; 1 until image accepted
//  done      out  1       image loaded and verified
//  err       out  1       load failed (size or checksum)
// BEHAVIOUR
//  Reset (async): state=HDR_HI; s_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, err=0,
//   word count, byte index, checksum accumulator = 0.
//  Stream format: N[15:8], N[7:0], then N words each 4 bytes big-endian (first byte -> [31:24]), then 1
//   checksum byte = XOR of all preceding bytes (header included).
//  States: HDR_HI -> HDR_LO -> DATA -> CHK -> DONE | ERR. Transitions only on accepted transfers.
//   HDR_LO: if N > IMEM_DEPTH -> ERR; if N == 0 -> CHK; else -> DATA.
//   DATA: byte index cycles 0..3; on 4th byte accepted, next cycle im_we=1 with im_wdata=full word,
//    im_addr=word index (0-based); im_addr increments after each write; after word N-1 -> CHK.
//   CHK: accepted byte == accumulated XOR -> DONE, else -> ERR.
//  s_ready = 1 in HDR_HI/HDR_LO/DATA/CHK, 0 in DONE/ERR. Bytes with s_valid=0 are ignored; stalls of any
//   length between bytes are allowed, with no state change.
//  im_we is a single-cycle pulse, registered; never asserted outside DATA-originated writes.
//  Accumulator XORs every accepted byte in HDR_HI, HDR_LO and DATA; the CHK byte is compared, not folded in.
//  cpu_rst: falls to 0 on the same edge that enters DONE; it stays 1 in every other state, including ERR.
//  done=1 only in DONE; err=1 only in ERR (sticky until reload or rst_n).
//  reload in DONE/ERR: next state HDR_HI, cpu_rst=1, done=err=0, im_addr/accumulator/counters cleared.
//   reload in any loading state is ignored. A reload coinciding with s_valid is taken; the byte is not consumed
//   (s_ready=0 that cycle).
//  rst_n low mid-load: immediate return to reset values; the partial IM image is left as written, not erased.
//  Final word write and entry to CHK: the im_we pulse for word N-1 may coincide with CHK byte acceptance.
// TESTING
//  1) Bytes 00 01 20 08 00 05 2C -> im_we once, im_addr=0, im_wdata=0x20080005; done=1, cpu_rst=0, err=0.
//  2) Same stream, checksum byte 2D -> no cpu_rst release; err=1, done=0, s_ready=0.
//  3) Header 01 01 (N=257 > 256) -> ERR entered after 2nd byte, no im_we pulse issued.
//  4) N=3 with random s_valid gaps -> exactly 3 writes, addresses 0,1,2, words match stream; done=1.
//  5) After DONE, pulse reload and resend test 1 -> cpu_rst back to 1 for the load, then 0; im_addr restarts at 0.
//  6) rst_n low after 2 payload bytes, then full valid stream -> clean load, no stale bytes in im_wdata.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses {N_hi, N_lo, N big-endian words, XOR checksum}, writes words into
// instruction memory and holds the pipeline in reset until a verified image has been loaded.
module imem_boot_loader #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        acc_q, acc_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       n_full;

    assign s_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign xfer    = s_valid & s_ready;
    assign n_full  = {n_q[15:8], s_data};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wcnt_d     = wcnt_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        acc_d      = acc_q;
        im_we_d    = 1'b0;
        im_wdata_d = im_wdata_q;
        // Address advances the cycle after each write pulse.
        im_addr_d  = im_we_q ? im_addr_q + ADDR_W'(1) : im_addr_q;

        case (state_q)
            ST_HDR_HI: begin
                if (xfer) begin
                    n_d     = {s_data, 8'h00};
                    acc_d   = acc_q ^ s_data;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    n_d   = n_full;
                    acc_d = acc_q ^ s_data;
                    if (32'(n_full) > IMEM_DEPTH) begin
                        state_d = ST_ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    acc_d  = acc_q ^ s_data;
                    bidx_d = bidx_q + 2'd1;
                    word_d = {word_q[15:0], s_data};
                    if (bidx_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = {word_q, s_data};
                        wcnt_d     = wcnt_q + 16'd1;
                        if (wcnt_q == n_q - 16'd1) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    state_d = (s_data == acc_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (reload) begin
                    state_d    = ST_HDR_HI;
                    n_d        = '0;
                    wcnt_d     = '0;
                    bidx_d     = '0;
                    word_d     = '0;
                    acc_d      = '0;
                    im_addr_d  = '0;
                    im_wdata_d = '0;
                end
            end
            default: state_d = ST_ERR;
        endcase

        cpu_rst_d = (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR_HI;
            n_q        <= '0;
            wcnt_q     <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            acc_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            acc_q      <= acc_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
